otter_scoreboard: RTL and testbench
===================================

# otter_scoreboard

Parametrised register scoreboard for the pipelined OTTER. It sits between decode and execute and holds an instruction in decode while any source register still has an outstanding write. It tracks, per architectural register, how many issued writes have not yet retired, which allows variable-latency units and several writeback ports. It replaces the pipeline's hazard-free assumption with an explicit valid/ready issue handshake.

## Interface
- NUM_REGS, 32, architectural registers tracked; x0 is never tracked
- CNT_W, 2, width of each per-register pending counter; at most 2^CNT_W-1 outstanding writes per register
- NUM_WB, 2, number of independent writeback/retire ports
- MAX_INFLIGHT, 4, cap on total outstanding tracked writes
- CLK  in  1  clock, all state updates on rising edge
- RESET  in  1  asynchronous, active-high reset
- ISSUE_VALID  in  1  decode presents an instruction
- ISSUE_READY  out  1  scoreboard accepts it this cycle
- ISSUE_RS1_ADDR, ISSUE_RS2_ADDR, ISSUE_RD_ADDR  in  5 each  register addresses
- ISSUE_RS1_USED, ISSUE_RS2_USED, ISSUE_RD_USED  in  1 each  operand-use flags
- WB_VALID  in  NUM_WB  per-port retire strobe; also used for squashed instructions, which retire without writing
- WB_RD_ADDR  in  NUM_WB*5  per-port retiring rd, port k at bits [5k+4:5k]
- FLUSH_ALL  in  1  clear every pending count (trap or mret with the pipeline drained)
- BUSY_VEC  out  NUM_REGS  bit r set when pending[r] != 0
- INFLIGHT  out  $clog2(MAX_INFLIGHT+1)  total outstanding tracked writes
- ERR  out  1  sticky; set on a retire to a register whose count is 0
- STALL_CNT  out  16  stall-cycle performance counter

## Operation
- A tracked write is an accepted issue with ISSUE_RD_USED=1 and ISSUE_RD_ADDR!=0.
- ISSUE_READY is combinational from registered state only:
  - low if rs1 is used, nonzero, and pending;
  - low if rs2 is used, nonzero, and pending;
  - low if the issue is a tracked write and pending[rd] = 2^CNT_W-1;
  - low if the issue is a tracked write and INFLIGHT = MAX_INFLIGHT;
  - high otherwise.
- Same-cycle retires do not raise ISSUE_READY. There is no bypass.
- Accept means ISSUE_VALID & ISSUE_READY. On accept, pending[rd] increments by 1 for a tracked write.
- Retire: each WB_VALID[k] with a nonzero address decrements pending[WB_RD_ADDR[k]].
  - Several ports naming the same register decrement it by the port count.
  - A decrement of a register at 0 is dropped and sets ERR.
  - Retires to x0 are ignored.
- The same register may be issued and retired in the same cycle. Net change = +issue - retires, applied in one update with no intermediate state.
- INFLIGHT = sum of all pending counts. It is maintained incrementally: +1 per tracked accept, minus the number of applied (non-dropped) decrements.
- FLUSH_ALL has priority over issue and retire in the same cycle. It zeroes all counts and INFLIGHT; ERR is unaffected.

## Timing
- Reset values: all counts 0, BUSY_VEC=0, INFLIGHT=0, ERR=0, STALL_CNT=0. ISSUE_READY is therefore 1 the first cycle after reset.
- RESET asserted mid-operation clears all state immediately; in-flight instructions are considered squashed.
- Issue-to-busy latency is 1 cycle: BUSY_VEC bit rises on the edge that accepts the issue.
- Retire-to-ready latency is 1 cycle: a dependent instruction stalled on rd sees ISSUE_READY high the cycle after the final retire of rd.
- ISSUE_READY must not depend on ISSUE_VALID. Issue inputs are held while VALID & !READY.

## Configuration
- OTTER_SB_PERF_EN defined: STALL_CNT increments on every cycle with ISSUE_VALID=1 and ISSUE_READY=0. It saturates at 16'hFFFF and is cleared only by RESET.
- OTTER_SB_PERF_EN undefined: STALL_CNT is tied to 0 and no counter flops exist.

## Structure
- Shared package otter_pipe_pkg holds:
  - opcode_t;
  - a reg_addr_t typedef (logic [4:0]);
  - the constant NUM_ARCH_REGS=32.
- The pipeline and the scoreboard both import otter_pipe_pkg.
- Sub-module otter_sb_counter: one per register r=1..NUM_REGS-1. It is a CNT_W-bit up/down counter with:
  - inputs inc (1 bit), dec_cnt ($clog2(NUM_WB+1) bits), clr;
  - outputs count, busy, and an underflow flag that feeds ERR.

## Test plan
- Reset, then issue rd=x5 → BUSY_VEC[5]=1 and INFLIGHT=1 next cycle. Issue an instruction reading rs1=x5 → ISSUE_READY=0. WB_VALID[0] with x5 → ISSUE_READY=1 one cycle later and BUSY_VEC[5]=0.
- Issue three writes to x7 with CNT_W=2 → pending[7]=3. A fourth write to x7 holds ISSUE_READY=0 until one retire of x7.
- Issue writes to x1..x4 → INFLIGHT=4 and a write to x9 stalls. Retire x1 and x2 on ports 0 and 1 in the same cycle → INFLIGHT=2 and the x9 write is accepted.
- With pending[3]=1, accept an issue writing x3 while WB_VALID[0] retires x3 → pending[3] stays 1 and INFLIGHT is unchanged.
- Retire x6 while it is idle → ERR=1 and stays 1. Then FLUSH_ALL together with an issue to x2 → all counts 0, BUSY_VEC=0, ERR still 1.
- With OTTER_SB_PERF_EN, hold a RAW stall for 10 cycles → STALL_CNT=10. Without the macro → STALL_CNT=0.

Source files
------------

// File: rtl/otter_pipe_pkg.sv
// otter_pipe_pkg: types and constants shared by the OTTER pipeline and its scoreboard.
package otter_pipe_pkg;
  localparam int NUM_ARCH_REGS = 32;
  typedef logic [4:0] reg_addr_t;
  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_IMM    = 7'b0010011,
    OP_REG    = 7'b0110011,
    OP_SYSTEM = 7'b1110011
  } opcode_t;
  function automatic logic reg_live(input logic used, input reg_addr_t addr);
    return used && addr != '0;
  endfunction
endpackage

// File: rtl/otter_sb_counter.sv
// otter_sb_counter: per-register pending-write counter; decrements beyond the current
// count are dropped and reported as underflow, applied_o is what was really subtracted.
module otter_sb_counter #(
  parameter int CNT_W = 2,
  parameter int DEC_W = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic [DEC_W-1:0] dec_cnt_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] count_o,
  output logic             busy_o,
  output logic             underflow_o,
  output logic [DEC_W-1:0] applied_o
);
  localparam int W = (CNT_W > DEC_W ? CNT_W : DEC_W) + 1;
  logic [CNT_W-1:0] count_q, count_d;
  logic [W-1:0] cnt_w, dec_w, app_w;
  always_comb begin
    cnt_w = W'(count_q);
    dec_w = W'(dec_cnt_i);
    app_w = dec_w > cnt_w ? cnt_w : dec_w;
    applied_o = DEC_W'(app_w);
    underflow_o = !clr_i && dec_w > cnt_w;
    count_d = clr_i ? '0 : CNT_W'(cnt_w + W'(inc_i) - app_w);
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) count_q <= '0;
    else count_q <= count_d;
  assign count_o = count_q;
  assign busy_o = count_q != '0;
endmodule

// File: rtl/otter_scoreboard.sv
// otter_scoreboard: per-register pending-write scoreboard gating decode->execute issue.
// Define OTTER_SB_PERF_EN to build the saturating stall-cycle counter on stall_cnt_o.
module otter_scoreboard
  import otter_pipe_pkg::*;
#(
  parameter int NUM_REGS     = NUM_ARCH_REGS,
  parameter int CNT_W        = 2,
  parameter int NUM_WB       = 2,
  parameter int MAX_INFLIGHT = 4,
  localparam int IF_W        = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                issue_valid_i,
  output logic                issue_ready_o,
  input  reg_addr_t           issue_rs1_addr_i,
  input  reg_addr_t           issue_rs2_addr_i,
  input  reg_addr_t           issue_rd_addr_i,
  input  logic                issue_rs1_used_i,
  input  logic                issue_rs2_used_i,
  input  logic                issue_rd_used_i,
  input  logic [NUM_WB-1:0]   wb_valid_i,
  input  logic [NUM_WB*5-1:0] wb_rd_addr_i,
  input  logic                flush_all_i,
  output logic [NUM_REGS-1:0] busy_vec_o,
  output logic [IF_W-1:0]     inflight_o,
  output logic                err_o,
  output logic [15:0]         stall_cnt_o
);
  localparam int DEC_W = $clog2(NUM_WB + 1);
  logic [CNT_W-1:0] count [1:NUM_REGS-1];
  logic [DEC_W-1:0] dec_cnt [1:NUM_REGS-1];
  logic [DEC_W-1:0] applied [1:NUM_REGS-1];
  logic [NUM_REGS-1:1] inc_vec, uflow_vec;
  logic [NUM_REGS-1:0] full_vec;
  logic [IF_W-1:0] inflight_q, inflight_d, applied_sum;
  logic err_q, wr, accept;
  assign wr = reg_live(issue_rd_used_i, issue_rd_addr_i);
  // Ready looks only at registered counts, so same-cycle retires never bypass.
  assign issue_ready_o = !((reg_live(issue_rs1_used_i, issue_rs1_addr_i) && busy_vec_o[issue_rs1_addr_i]) ||
                           (reg_live(issue_rs2_used_i, issue_rs2_addr_i) && busy_vec_o[issue_rs2_addr_i]) ||
                           (wr && (full_vec[issue_rd_addr_i] || inflight_q == IF_W'(MAX_INFLIGHT))));
  assign accept = issue_valid_i && issue_ready_o;
  assign busy_vec_o[0] = 1'b0;
  assign full_vec[0] = 1'b0;
  always_comb begin
    for (int r = 1; r < NUM_REGS; r++) begin
      dec_cnt[r] = '0;
      for (int k = 0; k < NUM_WB; k++)
        if (wb_valid_i[k] && wb_rd_addr_i[5*k +: 5] == 5'(r)) dec_cnt[r] = dec_cnt[r] + DEC_W'(1);
    end
  end
  for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
    assign inc_vec[r] = accept && wr && issue_rd_addr_i == 5'(r);
    otter_sb_counter #(.CNT_W(CNT_W), .DEC_W(DEC_W)) u_cnt (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .inc_i       (inc_vec[r]),
      .dec_cnt_i   (dec_cnt[r]),
      .clr_i       (flush_all_i),
      .count_o     (count[r]),
      .busy_o      (busy_vec_o[r]),
      .underflow_o (uflow_vec[r]),
      .applied_o   (applied[r])
    );
    assign full_vec[r] = count[r] == {CNT_W{1'b1}};
  end
  always_comb begin
    applied_sum = '0;
    for (int r = 1; r < NUM_REGS; r++) applied_sum = applied_sum + IF_W'(applied[r]);
    inflight_d = flush_all_i ? '0 : inflight_q + IF_W'(accept && wr) - applied_sum;
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      inflight_q <= '0;
      err_q <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      err_q <= err_q || (|uflow_vec);
    end
  assign inflight_o = inflight_q;
  assign err_o = err_q;
`ifdef OTTER_SB_PERF_EN
  logic [15:0] stall_cnt_q;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) stall_cnt_q <= '0;
    else if (issue_valid_i && !issue_ready_o && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = 16'd0;
`endif
endmodule

// File: tb/tb_otter_scoreboard.sv
// tb_otter_scoreboard: directed cycles push expected observations into a queue;
// a negedge monitor pops and compares them against the scoreboard outputs.
module tb_otter_scoreboard;
  import otter_pipe_pkg::*;
`ifdef OTTER_SB_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  typedef struct {
    string       name;
    logic        rdy;
    logic [31:0] busy;
    logic [2:0]  infl;
    logic        err;
    logic [15:0] stall;
  } exp_t;

  logic clk = 1'b0, rst = 1'b1;
  logic iv = 1'b0, u1 = 1'b0, u2 = 1'b0, ud = 1'b0, fl = 1'b0;
  reg_addr_t a1 = '0, a2 = '0, ad = '0;
  logic [1:0] wbv = '0;
  logic [9:0] wba = '0;
  logic rdy, err;
  logic [31:0] busy;
  logic [2:0] infl;
  logic [15:0] stall;
  exp_t q[$];
  int errors = 0, checks = 0, stall_exp = 0;

  always #5 clk = ~clk;

  otter_scoreboard dut (
    .clk_i(clk), .rst_i(rst), .issue_valid_i(iv), .issue_ready_o(rdy),
    .issue_rs1_addr_i(a1), .issue_rs2_addr_i(a2), .issue_rd_addr_i(ad),
    .issue_rs1_used_i(u1), .issue_rs2_used_i(u2), .issue_rd_used_i(ud),
    .wb_valid_i(wbv), .wb_rd_addr_i(wba), .flush_all_i(fl),
    .busy_vec_o(busy), .inflight_o(infl), .err_o(err), .stall_cnt_o(stall)
  );

  always @(negedge clk) if (q.size() > 0) begin
    exp_t e;
    e = q.pop_front();
    checks++;
    if (rdy !== e.rdy || busy !== e.busy || infl !== e.infl || err !== e.err || stall !== e.stall) begin
      errors++;
      $display("FAIL %s: got ready=%0b busy=%h inflight=%0d err=%0b stall=%0d, want ready=%0b busy=%h inflight=%0d err=%0b stall=%0d",
               e.name, rdy, busy, infl, err, stall, e.rdy, e.busy, e.infl, e.err, e.stall);
    end
  end

  task automatic step(input string name, input logic ar, input logic v,
                      input int r1, input logic f1, input int r2, input logic f2,
                      input int rd, input logic fd, input logic [1:0] wv, input int w0, input int w1,
                      input logic f, input logic e_rdy, input logic [31:0] e_busy,
                      input int e_inf, input logic e_err);
    exp_t e;
    @(posedge clk);
    #1;
    rst = ar;
    iv = v; a1 = 5'(r1); u1 = f1; a2 = 5'(r2); u2 = f2; ad = 5'(rd); ud = fd;
    wbv = wv; wba = {5'(w1), 5'(w0)}; fl = f;
    if (ar) stall_exp = 0;
    e.name = name; e.rdy = e_rdy; e.busy = e_busy; e.infl = 3'(e_inf); e.err = e_err;
    e.stall = PERF ? 16'(stall_exp) : 16'd0;
    q.push_back(e);
    if (!ar && v && !e_rdy) stall_exp++;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    //    name            ar v  r1 u1 r2 u2 rd ud wbv  w0 w1 fl rdy busy          inf err
    step("reset",         0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 32'h0,        0, 0);
    step("iss_x5",        0, 1, 0, 0, 0, 0, 5, 1, 2'b00, 0, 0, 0, 1, 32'h0,        0, 0);
    step("raw_x5",        0, 1, 5, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 32'h20,       1, 0);
    step("raw_same_wb",   0, 1, 5, 1, 0, 0, 0, 0, 2'b01, 5, 0, 0, 0, 32'h20,       1, 0);
    step("raw_go",        0, 1, 5, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 32'h0,        0, 0);
    step("x7_a",          0, 1, 0, 0, 0, 0, 7, 1, 2'b00, 0, 0, 0, 1, 32'h0,        0, 0);
    step("x7_b",          0, 1, 0, 0, 0, 0, 7, 1, 2'b00, 0, 0, 0, 1, 32'h80,       1, 0);
    step("x7_c",          0, 1, 0, 0, 0, 0, 7, 1, 2'b00, 0, 0, 0, 1, 32'h80,       2, 0);
    step("x7_full",       0, 1, 0, 0, 0, 0, 7, 1, 2'b00, 0, 0, 0, 0, 32'h80,       3, 0);
    step("x7_full2",      0, 1, 0, 0, 0, 0, 7, 1, 2'b00, 0, 0, 0, 0, 32'h80,       3, 0);
    step("x7_retire",     0, 1, 0, 0, 0, 0, 7, 1, 2'b01, 7, 0, 0, 0, 32'h80,       3, 0);
    step("x7_go",         0, 1, 0, 0, 0, 0, 7, 1, 2'b00, 0, 0, 0, 1, 32'h80,       2, 0);
    step("x7_drain2",     0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 7, 7, 0, 1, 32'h80,       3, 0);
    step("x7_drain1",     0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 7, 0, 0, 1, 32'h80,       1, 0);
    step("idle_a",        0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 32'h0,        0, 0);
    step("w_x1",          0, 1, 0, 0, 0, 0, 1, 1, 2'b00, 0, 0, 0, 1, 32'h0,        0, 0);
    step("w_x2",          0, 1, 0, 0, 0, 0, 2, 1, 2'b00, 0, 0, 0, 1, 32'h2,        1, 0);
    step("w_x3",          0, 1, 0, 0, 0, 0, 3, 1, 2'b00, 0, 0, 0, 1, 32'h6,        2, 0);
    step("w_x4",          0, 1, 0, 0, 0, 0, 4, 1, 2'b00, 0, 0, 0, 1, 32'hE,        3, 0);
    step("w_x9_cap",      0, 1, 0, 0, 0, 0, 9, 1, 2'b00, 0, 0, 0, 0, 32'h1E,       4, 0);
    step("x0_at_cap",     0, 1, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0, 1, 32'h1E,       4, 0);
    step("w_x9_ret12",    0, 1, 0, 0, 0, 0, 9, 1, 2'b11, 1, 2, 0, 0, 32'h1E,       4, 0);
    step("w_x9_go",       0, 1, 0, 0, 0, 0, 9, 1, 2'b00, 0, 0, 0, 1, 32'h18,       2, 0);
    step("x3_iss_ret",    0, 1, 0, 0, 0, 0, 3, 1, 2'b01, 3, 0, 0, 1, 32'h218,      3, 0);
    step("x3_net0_x0wb",  0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 1, 32'h218,      3, 0);
    step("ret_idle_x6",   0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 6, 0, 0, 1, 32'h218,      3, 0);
    step("err_set",       0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 32'h218,      3, 1);
    step("flush_iss_x2",  0, 1, 0, 0, 0, 0, 2, 1, 2'b00, 0, 0, 1, 1, 32'h218,      3, 1);
    step("flushed",       0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 32'h0,        0, 1);
    step("p_w5",          0, 1, 0, 0, 0, 0, 5, 1, 2'b00, 0, 0, 0, 1, 32'h0,        0, 1);
    for (int i = 0; i < 9; i++)
      step("p_stall",     0, 1, 0, 0, 5, 1, 0, 0, 2'b00, 0, 0, 0, 0, 32'h20,       1, 1);
    step("p_stall_wb",    0, 1, 0, 0, 5, 1, 0, 0, 2'b01, 5, 0, 0, 0, 32'h20,       1, 1);
    step("p_go",          0, 1, 0, 0, 5, 1, 0, 0, 2'b00, 0, 0, 0, 1, 32'h0,        0, 1);
    step("p_after",       0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 32'h0,        0, 1);
    step("r_w8",          0, 1, 0, 0, 0, 0, 8, 1, 2'b00, 0, 0, 0, 1, 32'h0,        0, 1);
    step("r_async",       1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 32'h0,        0, 0);
    step("r_release",     0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 32'h0,        0, 0);
    step("r_w8_again",    0, 1, 0, 0, 0, 0, 8, 1, 2'b00, 0, 0, 0, 1, 32'h0,        0, 0);
    step("r_check",       0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 32'h100,      1, 0);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations never checked, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
